uart_fifo: RTL and testbench
============================

// Module: uart_fifo
// PURPOSE
//  Next-generation bus-attached UART: TX/RX engines, parametrised FIFOs, runtime baud divisor,
//  5-8 data bits, optional parity, sticky error flags, maskable level IRQs. Drop-in for the
//  existing UART on the same slave bus (cs_/as_/rw/rdy_ handshake), with a 2-bit register address.
// PARAMETERS
//  DATA_W      8        max data bits (5..8); frame length set at runtime by CTRL.len
//  FIFO_DEPTH  16       entries per TX/RX FIFO, power of 2, >=2
//  DIV_W       16       baud divisor width
//  DIV_RESET   16'd434  clocks per bit after reset (50 MHz / 115200)
// PORTS
//  clk      in   1       system clock
//  reset    in   1       asynchronous, active-low reset
//  cs_      in   1       chip select, active low
//  as_      in   1       address strobe, active low
//  rw       in   1       1 = read, 0 = write
//  addr     in   2       register select: 0 STAT, 1 DATA, 2 DIV, 3 CTRL
//  wr_data  in   32      write data
//  rd_data  out  32      read data; 0 when rdy_ = 1
//  rdy_     out  1       access complete, active low
//  irq_rx   out  1       RX interrupt, level
//  irq_tx   out  1       TX interrupt, level
//  tx       out  1       serial out, idle high
//  rx       in   1       serial in, asynchronous; 2-flop synchronised internally
// BEHAVIOUR
//  Reset: rd_data=0, rdy_=1, irq_rx=0, irq_tx=0, tx=1; FIFOs empty; DIV=DIV_RESET; CTRL=0; flags=0.
//  Bus: access when cs_=0 && as_=0 at a rising edge -> rdy_=0 and rd_data valid on the next cycle
//   (1-cycle latency), single-cycle pulse. Side effects (push/pop/clear) occur once per access.
//  Registers:
//   STAT (R): [0] rx_nempty [1] tx_full [2] tx_idle (FIFO empty && FSM IDLE) [3] rx_ovr [4] par_err
//         [5] frm_err [6] tx_ovf [15:8] rx_count [23:16] tx_count.
//         (W): writing 1 to bits 3..6 clears that flag; a set event in the same cycle wins.
//   DATA (W): push wr_data[DATA_W-1:0] to TX FIFO; if full, drop it and set tx_ovf.
//        (R): pop RX FIFO, return data zero-extended; if empty, return 0 with no pop.
//   DIV  (R/W): clocks per bit; writes of values <4 are clamped to 4; a new value takes effect
//        at the next frame start, never mid-frame.
//   CTRL (R/W): [1:0] len (00=5..11=8 bits) [2] par_en [3] par_odd [4] rx_ie [5] tx_ie [6] stop2.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or -> START if FIFO non-empty).
//   Each state lasts DIV clocks (STOP lasts 2*DIV when stop2). LSB first. Parity = XOR of data
//   bits (even), inverted when par_odd. Pop occurs on the IDLE->START transition.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. A falling edge in IDLE starts the
//   half-bit counter; at DIV/2 rx must still be 0, else return to IDLE (glitch reject). Later
//   samples are taken every DIV clocks at bit centre. stop=0 -> frm_err; parity mismatch -> par_err;
//   the char is still pushed. Push when RX FIFO full -> char dropped, rx_ovr set.
//  FIFOs: pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide. Simultaneous
//   push+pop: when full, the pop is accepted and the push succeeds; when empty, the push is
//   accepted and the pop returns 0.
//  IRQs (registered): irq_rx = rx_ie & (rx_nempty | rx_ovr | par_err | frm_err);
//   irq_tx = tx_ie & tx_idle. CTRL writes are reflected in the IRQs the next cycle.
//  Reset mid-frame: tx returns to 1 asynchronously; partial frames are discarded.
// TESTING
//  1. DIV=4, CTRL len=8: write DATA 0x55 -> tx: 4 clk low, bits 1,0,1,0,1,0,1,0 x4 clk, 4 clk
//     high; tx_idle=1 afterwards.
//  2. Loop tx->rx, par_en=1, par_odd=1: send 0xA3 -> RX FIFO holds 0xA3, par_err=0, irq_rx=1 when rx_ie=1.
//  3. Write 17 bytes with FIFO_DEPTH=16 while TX is stalled -> tx_ovf=1, tx_count=16, byte 17 not sent.
//  4. Inject 17 frames with no reads -> rx_ovr=1, rx_count=16; first 16 bytes read back in order.
//  5. rx low for DIV/4 clocks then high -> no char received; stop bit forced 0 -> frm_err=1;
//     write STAT 0x20 -> frm_err clears.
//  6. Assert reset mid-DATA -> tx=1, FIFOs empty, DIV=434, rdy_=1, IRQs 0 immediately.

Source files
------------

// File: rtl/uart_fifo_if.sv
// Slave-bus bundle for uart_fifo: strobed register access with a one-cycle,
// active-low completion pulse.
interface uart_fifo_if;
  // An access is a cycle where cs_ and as_ are both low after having been
  // high; the slave answers with rdy_ low for exactly one cycle on the next
  // cycle, with rd_data valid only while rdy_ is low (0 otherwise).
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/uart_fifo.sv
// Bus-attached UART: TX/RX bit engines with FIFOs, runtime divisor and frame
// format, sticky error flags and maskable level interrupts.
module uart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     push_ok_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          pop_ok;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign count_o   = cnt_q;
  assign pop_ok    = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign push_ok_o = push_i && (!full_o || pop_ok);
  assign dout_o    = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok_o) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)    rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok_o) - CW'(pop_ok);
    end
  end
endmodule

module uart_fifo #(
  parameter int               DATA_W     = 8,
  parameter int               FIFO_DEPTH = 16,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(434)
) (
  input  logic       clk,
  input  logic       reset,
  uart_fifo_if.slave bus,
  output logic       irq_rx,
  output logic       irq_tx,
  output logic       tx,
  input  logic       rx,
  output logic [2:0] tx_state_o,
  output logic [2:0] rx_state_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Bus side
  logic              strobe, strobe_q, acc, wr, rd;
  logic [31:0]       rd_data_q, rd_data_d, rd_mux, stat;
  logic              rdy_n_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [6:0]        ctrl_q, ctrl_d;
  logic [3:0]        flags_q, flags_d, flags_set, flags_clr; // tx_ovf, frm, par, ovr
  logic              irq_rx_q, irq_tx_q;
  logic [3:0]        nbits;
  logic [BW-1:0]     last_bit;
  logic [DATA_W-1:0] len_mask;

  // FIFO wiring
  logic              tx_push, tx_push_ok, tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0] tx_dout;
  logic [CW-1:0]     tx_cnt;
  logic              rx_push, rx_push_ok, rx_pop, rx_empty, rx_full;
  logic [DATA_W-1:0] rx_dout, rx_din;
  logic [CW-1:0]     rx_cnt;

  // TX engine
  state_t            tx_state_q, tx_state_d;
  logic [DIV_W:0]    tx_cnt_q, tx_cnt_d, tx_stop_len;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d, tx_q, tx_d, tx_load, tx_idle;
  logic [DIV_W-1:0]  tx_div_q, tx_div_d;

  // RX engine
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  state_t            rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_par_q, rx_par_d, rx_perr_q, rx_perr_d;
  logic              rx_frm_set, rx_par_set;

  logic unused_bits;
  assign unused_bits = ^{bus.wr_data[31:DIV_W], rx_full};

  assign strobe   = !bus.cs_ && !bus.as_;
  assign acc      = strobe && !strobe_q;
  assign wr       = acc && !bus.rw;
  assign rd       = acc && bus.rw;
  assign nbits    = {2'b00, ctrl_q[1:0]} + 4'd5;
  assign last_bit = BW'(nbits - 4'd1);
  assign len_mask = ~({DATA_W{1'b1}} << nbits);

  assign tx_push = wr && (bus.addr == 2'd1);
  assign rx_pop  = rd && (bus.addr == 2'd1);
  assign tx_idle = tx_empty && (tx_state_q == S_IDLE);

  uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push_i(tx_push), .din_i(bus.wr_data[DATA_W-1:0]),
    .pop_i(tx_pop), .dout_o(tx_dout), .push_ok_o(tx_push_ok), .empty_o(tx_empty),
    .full_o(tx_full), .count_o(tx_cnt));

  uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push_i(rx_push), .din_i(rx_din),
    .pop_i(rx_pop), .dout_o(rx_dout), .push_ok_o(rx_push_ok), .empty_o(rx_empty),
    .full_o(rx_full), .count_o(rx_cnt));

  assign stat = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, flags_q, tx_idle, tx_full, !rx_empty};

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      2'd0: rd_mux = stat;
      2'd1: rd_mux = 32'(rx_dout);
      2'd2: rd_mux = 32'(div_q);
      2'd3: rd_mux = 32'(ctrl_q);
      default: rd_mux = '0;
    endcase
    rd_data_d = rd ? rd_mux : '0;

    div_d  = div_q;
    ctrl_d = ctrl_q;
    if (wr && bus.addr == 2'd2)
      div_d = (bus.wr_data[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : bus.wr_data[DIV_W-1:0];
    if (wr && bus.addr == 2'd3)
      ctrl_d = bus.wr_data[6:0];

    // Set events override a simultaneous write-1-to-clear.
    flags_clr = (wr && bus.addr == 2'd0) ? bus.wr_data[6:3] : 4'h0;
    flags_set = {tx_push && !tx_push_ok, rx_frm_set, rx_par_set, rx_push && !rx_push_ok};
    flags_d   = (flags_q & ~flags_clr) | flags_set;
  end

  assign tx_stop_len = ctrl_q[6] ? ({tx_div_q, 1'b0} - 1'b1) : ({1'b0, tx_div_q} - 1'b1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_div_d   = tx_div_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) tx_load = 1'b1;
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = {1'b0, tx_div_q} - 1'b1;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = {1'b0, tx_div_q} - 1'b1;
          if (tx_bit_q == last_bit) begin
            if (ctrl_q[2]) begin
              tx_state_d = S_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_cnt_d   = tx_stop_len;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = tx_stop_len;
          tx_d       = 1'b1;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_IDLE;
          tx_d       = 1'b1;
          if (!tx_empty) tx_load = 1'b1;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Divisor and parity are captured here so a DIV write never disturbs a frame.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_d    = tx_dout;
      tx_par_d   = (^(tx_dout & len_mask)) ^ ctrl_q[3];
      tx_div_d   = div_q;
      tx_cnt_d   = {1'b0, div_q} - 1'b1;
      tx_state_d = S_START;
      tx_d       = 1'b0;
    end
  end

  assign rx_din = rx_sh_q >> (4'(DATA_W) - nbits);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_frm_set = 1'b0;
    rx_par_set = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
          rx_cnt_d   = (div_q >> 1) - 1'b1;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = S_DATA;
            rx_cnt_d   = rx_div_q - 1'b1;
            rx_bit_d   = '0;
            rx_par_d   = 1'b0;
            rx_perr_d  = 1'b0;
          end else rx_state_d = S_IDLE;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
          rx_par_d = rx_par_q ^ rx_s2_q;
          rx_cnt_d = rx_div_q - 1'b1;
          if (rx_bit_q == last_bit) rx_state_d = ctrl_q[2] ? S_PARITY : S_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_perr_d  = rx_s2_q ^ rx_par_q ^ ctrl_q[3];
          rx_state_d = S_STOP;
          rx_cnt_d   = rx_div_q - 1'b1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_push    = 1'b1;
          rx_frm_set = !rx_s2_q;
          rx_par_set = rx_perr_q;
          rx_state_d = S_IDLE;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q   <= 1'b0;
      rd_data_q  <= '0;
      rdy_n_q    <= 1'b1;
      div_q      <= DIV_RESET;
      ctrl_q     <= '0;
      flags_q    <= '0;
      irq_rx_q   <= 1'b0;
      irq_tx_q   <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_div_q   <= DIV_RESET;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      strobe_q   <= strobe;
      rd_data_q  <= rd_data_d;
      rdy_n_q    <= !acc;
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      flags_q    <= flags_d;
      irq_rx_q   <= ctrl_q[4] & (!rx_empty | (|flags_q[2:0]));
      irq_tx_q   <= ctrl_q[5] & tx_idle;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_div_q   <= tx_div_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rdy_    = rdy_n_q;
  assign irq_rx      = irq_rx_q;
  assign irq_tx      = irq_tx_q;
  assign tx          = tx_q;
  assign tx_state_o  = tx_state_q;
  assign rx_state_o  = rx_state_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: bus reads are scored by a monitor against an
// expected queue; serial waveforms and pins are checked inline.
module tb_uart_fifo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_fifo_if bus();
  logic       tx, irq_rx, irq_tx, rx_drv, loop_en, rx_line;
  logic [2:0] tx_st, rx_st;
  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo dut (
    .clk(clk), .reset(reset), .bus(bus), .irq_rx(irq_rx), .irq_tx(irq_tx),
    .tx(tx), .rx(rx_line), .tx_state_o(tx_st), .rx_state_o(rx_st));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] msk_q[$];
  string       name_q[$];
  logic [31:0] mon_e, mon_m;
  string       mon_n;
  logic [7:0]  tab [17] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h11,
                            8'h22, 8'h44, 8'h88, 8'h7E, 8'hE7, 8'h0F, 8'hF0, 8'h99};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rdy_ pulse consumes one scoreboard entry; mask 0 = write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rdy_ === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rdy: got rdy_=0, expected no access");
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = msk_q.pop_front();
        mon_n = name_q.pop_front();
        if (mon_m != 32'h0) check(mon_n, bus.rd_data & mon_m, mon_e);
      end
    end
  end

  task automatic bus_acc(input logic r, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] e, input logic [31:0] m, input string n);
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(n);
    @(negedge clk);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = r; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs_ = 1'b1; bus.as_ = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_acc(1'b0, a, d, 32'h0, 32'h0, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m, input string n);
    bus_acc(1'b1, a, 32'h0, e, m, n);
  endtask

  // Drive one 8-bit frame on rx at 4 clocks per bit.
  task automatic send_frame(input logic [7:0] b, input logic par_en, input logic par_bit,
                            input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (4) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = par_bit;
      repeat (4) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Sample tx 4 times per bit from the first low sample of the start bit.
  task automatic capture_tx(input logic [7:0] b);
    logic [9:0] expv;
    logic [3:0] got;
    int t;
    expv = {1'b1, b, 1'b0};
    t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL tx_start_timeout: got tx=%b, expected start bit within 100 cycles", tx);
    end else begin
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < 4; j++) begin
          got[j] = tx;
          @(negedge clk);
        end
        check($sformatf("tx_bit%0d", k), 32'(got), 32'({4{expv[k]}}));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion, expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = 2'd0; bus.wr_data = 32'h0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_rdy", 32'(bus.rdy_), 32'h1);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_irq", {30'h0, irq_rx, irq_tx}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    rd(2'd0, 32'h0000_0004, 32'hFFFF_FFFF, "stat_reset");
    rd(2'd2, 32'd434, 32'hFFFF_FFFF, "div_reset");
    rd(2'd3, 32'h0, 32'hFFFF_FFFF, "ctrl_reset");

    // Divisor write and clamp, then an 8N1 frame of 0x55
    wr(2'd2, 32'd4);
    rd(2'd2, 32'd4, 32'hFFFF_FFFF, "div_4");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd4, 32'hFFFF_FFFF, "div_clamp");
    wr(2'd3, 32'h03);
    wr(2'd1, 32'h55);
    capture_tx(8'h55);
    repeat (2) @(negedge clk);
    rd(2'd0, 32'h4, 32'h7, "tx_idle_after");
    wr(2'd3, 32'h23);
    repeat (2) @(negedge clk);
    check("irq_tx", 32'(irq_tx), 32'h1);

    // Loopback with odd parity
    loop_en = 1'b1;
    wr(2'd3, 32'h1F);
    wr(2'd1, 32'hA3);
    repeat (80) @(negedge clk);
    check("irq_rx_loop", 32'(irq_rx), 32'h1);
    rd(2'd0, 32'h0000_0105, 32'h0000_FF3F, "stat_loop");
    rd(2'd1, 32'hA3, 32'hFFFF_FFFF, "data_loop");
    rd(2'd0, 32'h0000_0004, 32'h0000_FF3F, "stat_loop_empty");
    repeat (2) @(negedge clk);
    check("irq_rx_clear", 32'(irq_rx), 32'h0);

    // Loopback with 5-bit frames
    wr(2'd3, 32'h10);
    wr(2'd1, 32'hF5);
    repeat (60) @(negedge clk);
    rd(2'd1, 32'h15, 32'hFFFF_FFFF, "data_len5");
    loop_en = 1'b0;

    // RX overflow: 17 frames, no reads
    wr(2'd3, 32'h03);
    for (int i = 0; i < 17; i++) send_frame(tab[i], 1'b0, 1'b0, 1'b1);
    rd(2'd0, 32'h0000_1009, 32'h0000_FF09, "stat_rx_ovr");
    for (int i = 0; i < 16; i++) rd(2'd1, 32'(tab[i]), 32'hFFFF_FFFF, $sformatf("rx_data%0d", i));
    rd(2'd1, 32'h0, 32'hFFFF_FFFF, "rx_empty_read");
    rd(2'd0, 32'h0000_0008, 32'h0000_FF09, "stat_ovr_sticky");
    wr(2'd0, 32'h08);
    rd(2'd0, 32'h0, 32'h0000_FF09, "stat_ovr_clear");

    // Glitch reject, then a framing error
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd(2'd0, 32'h0, 32'h0000_FF01, "glitch_reject");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rd(2'd0, 32'h0000_0121, 32'h0000_FF21, "stat_frm");
    rd(2'd1, 32'h3C, 32'hFFFF_FFFF, "data_frm");
    wr(2'd0, 32'h20);
    rd(2'd0, 32'h0, 32'h38, "frm_clear");

    // Parity error: even parity, wrong parity bit
    wr(2'd3, 32'h07);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    rd(2'd0, 32'h11, 32'h31, "stat_par");
    rd(2'd1, 32'h01, 32'hFFFF_FFFF, "data_par");
    wr(2'd0, 32'h10);
    rd(2'd0, 32'h0, 32'h10, "par_clear");

    // TX overflow behind a slow frame, then reset mid-frame
    wr(2'd3, 32'h13);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("irq_rx_pre_reset", 32'(irq_rx), 32'h1);
    wr(2'd2, 32'd200);
    wr(2'd1, 32'hEE);
    for (int i = 1; i <= 17; i++) wr(2'd1, 32'(i));
    rd(2'd0, 32'h0010_0042, 32'h00FF_0046, "stat_tx_ovf");
    repeat (250) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(tx), 32'h1);
    check("midframe_rst_rdy", 32'(bus.rdy_), 32'h1);
    check("midframe_rst_irq", {30'h0, irq_rx, irq_tx}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(2'd0, 32'h0000_0004, 32'hFFFF_FFFF, "stat_after_rst");
    rd(2'd2, 32'd434, 32'hFFFF_FFFF, "div_after_rst");
    rd(2'd1, 32'h0, 32'hFFFF_FFFF, "rx_after_rst");
    repeat (20) @(negedge clk);
    check("tx_quiet_after_rst", 32'(tx), 32'h1);

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
